fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core: requests instruction memory, hands fetched words to decode with a valid/ready handshake, and applies branch redirects and halt.
- Branch encoding and the rule that the taken target is absolute match the core's PC convention.
- Sits between instruction memory and decode; replaces the free-running PC with a start/done controlled sequencer.

Parameters:
D, 12, program counter / instruction address width
IW, 9, instruction word width
TMO, 15, max cycles in FETCH waiting for imem_ack before error halt
CW, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin execution at start_pc; honoured in IDLE or HALT only
start_pc  in  D  initial fetch address
imem_req  out  1  instruction memory request
imem_addr  out  D  fetch address, equals prog_ctr
imem_ack  in  1  read data valid this cycle
imem_rdata  in  IW  instruction word
instr_valid  out  1  instr holds a fetched word for decode
instr_ready  in  1  decode accepts instr this cycle
instr  out  IW  registered instruction word
instr_pc  out  D  address of instr
br_kind  in  2  with accepted instr: 00 none, 01 taken if jcnd, 10 taken if !jcnd, 11 always
jcnd  in  1  branch condition flag
target  in  D  absolute branch target
halt_req  in  1  with accepted instr: stop after this instruction
prog_ctr  out  D  current PC
done  out  1  level, high in HALT
err  out  1  level, high when halted by fetch timeout
retired  out  CW  count of accepted instructions, saturating

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT (2-bit encoding).
- Reset: state IDLE; prog_ctr, instr, instr_pc, retired, and the timeout counter all 0. imem_req, instr_valid, done, err = 0. Reset asserted mid-operation aborts immediately; an outstanding imem request is dropped and a late imem_ack is ignored in IDLE.
- IDLE: outputs idle. start=1 -> prog_ctr<=start_pc, retired<=0, err<=0, go FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=prog_ctr.
  - imem_ack=1 -> instr<=imem_rdata, instr_pc<=prog_ctr, go ISSUE. Ack may arrive in the first FETCH cycle, so minimum latency is 1 cycle.
  - Timeout counter resets on entry and increments each FETCH cycle without ack. When it reaches TMO (TMO consecutive cycles without ack) -> err<=1, go HALT; an ack in that same cycle wins over the timeout.
- ISSUE:
  - instr_valid=1. instr and instr_pc are held stable until instr_ready; instr_valid never drops without acceptance.
  - On instr_ready: retired increments, saturating at 2^CW-1.
    - halt_req=1 -> go HALT; prog_ctr unchanged. Halt beats any branch in the same cycle.
    - Otherwise, branch taken (br_kind 11, or 01 with jcnd=1, or 10 with jcnd=0) -> prog_ctr<=target, go FETCH.
    - Otherwise prog_ctr<=prog_ctr+1, modulo 2^D (2^D-1 wraps to 0), go FETCH.
  - br_kind, jcnd, target and halt_req are sampled only in the accept cycle.
- HALT: done=1, err holds. start=1 -> behaves as in IDLE (reload start_pc, clear retired and err, go FETCH).
- start is ignored in FETCH and ISSUE.
- Throughput: at most one instruction per 2 cycles (FETCH, ISSUE); no prefetch.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- Shared package core_pkg holds:
  - enum br_kind_t {BR_NONE, BR_JC, BR_JNC, BR_ALWAYS}
  - enum fetch_state_t {IDLE, FETCH, ISSUE, HALT}
  - localparam PC_W=12
- Sub-module pc_next: combinational next-PC select (taken/not taken, +1 wrap). It is shareable with the existing PC logic.

Test Plan:
- start_pc=0x010, imem_ack one cycle after each req, instr_ready=1, no branches, halt_req on 4th instr -> imem_addr sequence 0x010,0x011,0x012,0x013; done=1; retired=4; prog_ctr=0x013.
- Hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid stays 1; instr and instr_pc stable; imem_req=0; retired unchanged.
- On accept: br_kind=01 with jcnd=1 and target=0x200 -> next imem_addr 0x200. Then br_kind=10 with jcnd=1 -> next imem_addr 0x201. Then br_kind=11 with target=0x005 -> 0x005.
- start_pc=0xFFF, no branch -> second fetch address 0x000 (wrap).
- Halt and timeout:
  - halt_req=1 together with br_kind=11 -> HALT, prog_ctr unchanged.
  - imem_ack withheld -> err=1, done=1 after exactly TMO=15 FETCH cycles.
  - start in HALT -> err=0, retired=0, fetch restarts.
- Drive reset=0 mid-FETCH, then a late imem_ack -> state IDLE, all outputs 0, ack ignored; start afterwards resumes normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core's fetch path.
//   PC_W          : default program counter / instruction address width
//   br_kind_t     : branch kind presented by decode with an accepted instruction
//   fetch_state_t : fetch sequencer state encoding (2 bits)
//   branch_taken  : resolves a branch kind against the condition flag
package core_pkg;

    localparam int PC_W = 12;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,  // fall through
        BR_JC     = 2'b01,  // taken when jcnd = 1
        BR_JNC    = 2'b10,  // taken when jcnd = 0
        BR_ALWAYS = 2'b11   // unconditional
    } br_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic logic branch_taken(input br_kind_t kind, input logic jcnd);
        logic t;
        t = 1'b0;
        case (kind)
            BR_NONE:   t = 1'b0;
            BR_JC:     t = jcnd;
            BR_JNC:    t = ~jcnd;
            BR_ALWAYS: t = 1'b1;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select.
//   pc      : current program counter
//   br_kind : branch kind (see core_pkg::br_kind_t)
//   jcnd    : branch condition flag
//   target  : absolute branch target
//   taken   : branch resolved as taken
//   next_pc : target when taken, else pc + 1 wrapping modulo 2^D
module pc_next
    import core_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic [D-1:0] pc,
    input  logic [1:0]   br_kind,
    input  logic         jcnd,
    input  logic [D-1:0] target,
    output logic         taken,
    output logic [D-1:0] next_pc
);

    assign taken   = branch_taken(br_kind_t'(br_kind), jcnd);
    // Sequential increment relies on natural D-bit truncation for the wrap.
    assign next_pc = taken ? target : (pc + D'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, requests instruction memory,
// hands each fetched word to decode over a valid/ready handshake, and applies
// branch redirects, halt and fetch-timeout error.
//   clk, reset               : clock (rising edge), asynchronous active-low reset
//   start, start_pc          : begin execution at start_pc (IDLE/HALT only)
//   imem_req/addr/ack/rdata  : instruction memory request / response
//   instr_valid/ready        : handshake with decode
//   instr, instr_pc          : registered instruction word and its address
//   br_kind, jcnd, target    : branch info, sampled with the accepted instr
//   halt_req                 : stop after the accepted instr
//   prog_ctr                 : current PC
//   done, err                : halted / halted by fetch timeout
//   retired                  : saturating count of accepted instructions
// One instruction every two cycles at best (FETCH then ISSUE), no prefetch.
// Every output is a register or a decode of the state register.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int D   = PC_W,
    parameter int IW  = 9,
    parameter int TMO = 15,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_pc,
    output logic          imem_req,
    output logic [D-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [D-1:0]  instr_pc,
    input  logic [1:0]    br_kind,
    input  logic          jcnd,
    input  logic [D-1:0]  target,
    input  logic          halt_req,
    output logic [D-1:0]  prog_ctr,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] retired
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_HALT  = HALT;

    localparam int          TW       = (TMO < 2) ? 1 : $clog2(TMO);
    // Last no-ack cycle before giving up: counter holds the number of
    // completed no-ack cycles, so the TMO-th one sees TMO-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [1:0]    state_reg,    state_next;
    logic [TW-1:0] tmo_cnt_reg,  tmo_cnt_next;
    logic [D-1:0]  prog_ctr_reg, prog_ctr_next;
    logic [IW-1:0] instr_reg,    instr_next;
    logic [D-1:0]  instr_pc_reg, instr_pc_next;
    logic [CW-1:0] retired_reg,  retired_next;
    logic          err_reg,      err_next;

    logic [D-1:0]  pc_after;
    logic          br_taken;

    pc_next #(.D(D)) u_pc_next (
        .pc      (prog_ctr_reg),
        .br_kind (br_kind),
        .jcnd    (jcnd),
        .target  (target),
        .taken   (br_taken),
        .next_pc (pc_after)
    );

    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        prog_ctr_next = prog_ctr_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        retired_next  = retired_reg;
        err_next      = err_reg;

        case (state_reg)
            S_IDLE, S_HALT: begin
                if (start) begin
                    prog_ctr_next = start_pc;
                    retired_next  = '0;
                    err_next      = 1'b0;
                    tmo_cnt_next  = '0;
                    state_next    = S_FETCH;
                end
            end

            S_FETCH: begin
                // An ack in the final timeout cycle still wins.
                if (imem_ack) begin
                    instr_next    = imem_rdata;
                    instr_pc_next = prog_ctr_reg;
                    tmo_cnt_next  = '0;
                    state_next    = S_ISSUE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    err_next     = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = S_HALT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end

            S_ISSUE: begin
                if (instr_ready) begin
                    if (retired_reg != '1) begin
                        retired_next = retired_reg + CW'(1);
                    end
                    // Halt takes priority over any branch on the same instr.
                    if (halt_req) begin
                        state_next = S_HALT;
                    end else begin
                        prog_ctr_next = pc_after;
                        tmo_cnt_next  = '0;
                        state_next    = S_FETCH;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            tmo_cnt_reg  <= '0;
            prog_ctr_reg <= '0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            retired_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            prog_ctr_reg <= prog_ctr_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            retired_reg  <= retired_next;
            err_reg      <= err_next;
        end
    end

    // br_taken is informational here; the select already folds it in.
    logic unused_taken;
    assign unused_taken = br_taken;

    assign imem_req    = (state_reg == S_FETCH);
    assign imem_addr   = prog_ctr_reg;
    assign instr_valid = (state_reg == S_ISSUE);
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign prog_ctr    = prog_ctr_reg;
    assign done        = (state_reg == S_HALT);
    assign err         = err_reg;
    assign retired     = retired_reg;

endmodule
